inbuf_frame_ctrl: RTL and testbench
===================================

Name: inbuf_frame_ctrl

Overview:
- Frame-level sequencer for the input-buffer address generator and polyphase FIR resampler.
- Sits between the sample source and the input-buffer address block.
- Per frame, it sequences three steps: tail-to-head history copy (InCopy), the FIR start pulse, and output counting until the frame's output samples are written.
- Gates the sample strobe so writes never collide with the copy, latches the tone mode per frame, and flags overruns.

Parameters:
- OUT_LEN, 570: OutBufwea pulses per frame (frame input span × I/D); frame completes on the OUT_LEN-th pulse.
- COPY_TMO, 32: max cycles in COPY before InCopyEnd; exceeding it sets err_copy.
- CNT_BITS, 16: frame_cnt width.

Ports:
- sys_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; run frames while high.
- mode_req  in  1  requested tone direction; sampled at frame start only.
- ready_in  in  1  one-cycle new-sample strobe from the source.
- ProcessStart  in  1  one-cycle pulse from the address block: frame fill complete.
- InCopyEnd  in  1  copy counter carry from the address block.
- OutBufwea  in  1  output-buffer write strobe, one per FIR output.
- clr_err  in  1  synchronous clear of sticky error flags.
- ready  out  1  gated sample strobe to the address block.
- InCopy  out  1  high during the history copy.
- FirStart  out  1  one-cycle FIR phase/address load pulse.
- RisingTone  out  1  latched tone mode, stable for a whole frame.
- busy  out  1  high in COPY/START/PROCESS.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_cnt  out  CNT_BITS  completed frames, wraps.
- overrun  out  1  sticky: ProcessStart arrived with one already pending.
- err_copy  out  1  sticky: COPY timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; internal counters 0; pend=0; hold=0.
- States: IDLE, WAIT, COPY, START, PROCESS.
- IDLE→WAIT when enable=1. WAIT→IDLE when enable=0.
- WAIT→COPY on ProcessStart (or when pend=1). On entry: RisingTone<=mode_req, pend<=0, InCopy=1 from the next cycle (1-cycle latency from ProcessStart).
- COPY:
  - InCopy stays 1 until the cycle InCopyEnd=1 is seen; then →START, with InCopy=0 the following cycle.
  - If the timeout counter reaches COPY_TMO first: set err_copy, drop InCopy, →START anyway.
- START: FirStart=1 for exactly one cycle; out counter cleared; →PROCESS.
- PROCESS:
  - Count OutBufwea pulses.
  - On the OUT_LEN-th pulse: frame_done=1 next cycle; frame_cnt+1 (wraps at 2^CNT_BITS).
  - Next state: →COPY if pend=1 and enable=1; else →WAIT if enable=1; else →IDLE.
- ProcessStart in COPY/START/PROCESS: if pend=0, set pend; if pend=1, set overrun (the extra event is dropped).
- Simultaneous ProcessStart and frame completion: the event is treated as pending, so the next state is COPY.
- enable=0 mid-frame: the current frame finishes; pend is discarded; →IDLE.
- Ready gating:
  - Outside COPY: ready=ready_in, combinational pass-through.
  - In COPY: ready=0. The first ready_in sets hold. A second ready_in while hold=1 sets overrun.
  - The cycle after InCopy falls: ready=1 if hold, then hold is cleared. A coincident ready_in that cycle is OR'd in; if hold is also set, overrun is set.
- clr_err=1 clears overrun and err_copy. A same-cycle set wins over the clear.
- RisingTone never changes outside COPY entry.

Decomposition:
- Shared package: state encoding (3-bit localparams IDLE/WAIT/COPY/START/PROCESS); OUT_LEN and COPY_LEN constants shared with the address block (COPY_LEN=21).
- One natural sub-module: sample_skid, the one-entry ready hold/replay with overrun detect.
- FSM and counters stay in the top level.

Test Plan:
- Reset then enable=1, ProcessStart at cycle 10 → InCopy high cycles 11..N; InCopyEnd at N → FirStart single pulse at N+2; 570 OutBufwea → frame_done one cycle after the 570th; frame_cnt=1.
- ready_in pulse during COPY → ready=0 during COPY, exactly one ready pulse the cycle after InCopy falls; overrun=0.
- Two ready_in pulses during COPY → overrun=1 and stays 1; clr_err → overrun=0.
- ProcessStart during PROCESS → after frame_done goes directly to COPY; second ProcessStart in the same frame → overrun=1.
- mode_req toggled mid-PROCESS → RisingTone unchanged until the next COPY entry.
- InCopyEnd withheld → err_copy=1 after 32 cycles, FirStart still issued. Separately: reset asserted mid-PROCESS → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/inbuf_frame_ctrl_pkg.sv
// Shared constants and state encoding for the input-buffer frame sequencer
// and the address block it drives.
package inbuf_frame_ctrl_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WAIT    = 3'd1;
   localparam logic [2:0] COPY    = 3'd2;
   localparam logic [2:0] START   = 3'd3;
   localparam logic [2:0] PROCESS = 3'd4;

   localparam int unsigned OUT_LEN  = 570;
   localparam int unsigned COPY_LEN = 21;
   localparam int unsigned COPY_TMO = 32;

   typedef enum logic [2:0] {
      StIdle    = IDLE,
      StWait    = WAIT,
      StCopy    = COPY,
      StStart   = START,
      StProcess = PROCESS
   } state_e;

endpackage

// File: rtl/inbuf_frame_ctrl_sample_skid.sv
// One-entry hold for a sample strobe that lands during the history copy;
// the held strobe is replayed on the first cycle after the copy ends.
module inbuf_frame_ctrl_sample_skid (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_copy_i,
   input  logic ready_in_i,
   output logic ready_o,
   output logic overrun_set_o
);
   import inbuf_frame_ctrl_pkg::*;

   logic hold_q, hold_d;

   always_comb begin
      hold_d = 1'b0;
      if (in_copy_i) begin
         hold_d = hold_q | ready_in_i;
      end
   end

   // hold_q is only ever high outside the copy on the replay cycle
   assign ready_o       = ~in_copy_i & (ready_in_i | hold_q);
   assign overrun_set_o = ready_in_i & hold_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/inbuf_frame_ctrl.sv
// Frame sequencer: history copy, FIR start pulse and output counting per frame,
// with sample-strobe gating, per-frame tone latch and sticky error flags.
module inbuf_frame_ctrl #(
   parameter int unsigned OUT_LEN  = inbuf_frame_ctrl_pkg::OUT_LEN,
   parameter int unsigned COPY_TMO = inbuf_frame_ctrl_pkg::COPY_TMO,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                sys_clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                mode_req,
   input  logic                ready_in,
   input  logic                ProcessStart,
   input  logic                InCopyEnd,
   input  logic                OutBufwea,
   input  logic                clr_err,
   output logic                ready,
   output logic                InCopy,
   output logic                FirStart,
   output logic                RisingTone,
   output logic                busy,
   output logic                frame_done,
   output logic [CNT_BITS-1:0] frame_cnt,
   output logic                overrun,
   output logic                err_copy
);
   import inbuf_frame_ctrl_pkg::*;

   localparam int unsigned OutW = $clog2(OUT_LEN + 1);
   localparam int unsigned TmoW = $clog2(COPY_TMO + 1);

   state_e              state_q, state_d;
   logic                pend_q, pend_d;
   logic [OutW-1:0]     out_cnt_q, out_cnt_d;
   logic [TmoW-1:0]     tmo_q, tmo_d;
   logic                tone_q, tone_d;
   logic [CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
   logic                fir_start_q, frame_done_q, done_d;
   logic                overrun_q, err_copy_q;
   logic                in_copy, busy_w, frame_last, ps_extra, tmo_set, skid_ovr;

   assign in_copy    = (state_q == StCopy);
   assign busy_w     = (state_q == StCopy) || (state_q == StStart) || (state_q == StProcess);
   assign frame_last = (state_q == StProcess) && OutBufwea &&
                       (out_cnt_q == OutW'(OUT_LEN - 1));

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      out_cnt_d   = out_cnt_q;
      tmo_d       = tmo_q;
      tone_d      = tone_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = 1'b0;
      ps_extra    = 1'b0;
      tmo_set     = 1'b0;

      // Only one frame start can be queued; a further one is dropped and flagged
      if (busy_w && ProcessStart) begin
         if (pend_q) ps_extra = 1'b1;
         else        pend_d   = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            pend_d = 1'b0;
            if (enable) state_d = StWait;
         end
         StWait: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (ProcessStart || pend_q) begin
               state_d = StCopy;
               tone_d  = mode_req;
               pend_d  = pend_q & ProcessStart;
               tmo_d   = '0;
            end
         end
         StCopy: begin
            if (InCopyEnd) begin
               state_d = StStart;
            end else if (tmo_q == TmoW'(COPY_TMO - 1)) begin
               state_d = StStart;
               tmo_set = 1'b1;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StStart: begin
            out_cnt_d = '0;
            state_d   = StProcess;
         end
         StProcess: begin
            if (OutBufwea) out_cnt_d = out_cnt_q + OutW'(1);
            if (frame_last) begin
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + CNT_BITS'(1);
               pend_d      = 1'b0;
               if (enable && (pend_q || ProcessStart)) begin
                  state_d = StCopy;
                  tone_d  = mode_req;
                  tmo_d   = '0;
               end else if (enable) begin
                  state_d = StWait;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         pend_q       <= 1'b0;
         out_cnt_q    <= '0;
         tmo_q        <= '0;
         tone_q       <= 1'b0;
         frame_cnt_q  <= '0;
         fir_start_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         err_copy_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         out_cnt_q    <= out_cnt_d;
         tmo_q        <= tmo_d;
         tone_q       <= tone_d;
         frame_cnt_q  <= frame_cnt_d;
         fir_start_q  <= (state_q == StStart);
         frame_done_q <= done_d;
         // A set in the same cycle as clr_err wins
         overrun_q    <= ps_extra | skid_ovr | (overrun_q & ~clr_err);
         err_copy_q   <= tmo_set | (err_copy_q & ~clr_err);
      end
   end

   inbuf_frame_ctrl_sample_skid u_skid (
      .clk_i         (sys_clk),
      .rst_ni        (reset),
      .in_copy_i     (in_copy),
      .ready_in_i    (ready_in),
      .ready_o       (ready),
      .overrun_set_o (skid_ovr)
   );

   assign InCopy     = in_copy;
   assign busy       = busy_w;
   assign FirStart   = fir_start_q;
   assign RisingTone = tone_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign overrun    = overrun_q;
   assign err_copy   = err_copy_q;

endmodule

// File: tb/tb_inbuf_frame_ctrl.sv
// Bench for inbuf_frame_ctrl: directed frame sequences with a scoreboard
// of expected frame completions (cycle and frame count).
module tb_inbuf_frame_ctrl;

   localparam int OUT_LEN  = 570;
   localparam int CNT_BITS = 16;

   logic                sys_clk = 1'b0;
   logic                reset, enable, mode_req, ready_in, ProcessStart;
   logic                InCopyEnd, OutBufwea, clr_err;
   logic                ready, InCopy, FirStart, RisingTone, busy, frame_done;
   logic [CNT_BITS-1:0] frame_cnt;
   logic                overrun, err_copy;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   exp_frames = 0;
   logic exp_tone = 1'b0;

   inbuf_frame_ctrl dut (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .enable       (enable),
      .mode_req     (mode_req),
      .ready_in     (ready_in),
      .ProcessStart (ProcessStart),
      .InCopyEnd    (InCopyEnd),
      .OutBufwea    (OutBufwea),
      .clr_err      (clr_err),
      .ready        (ready),
      .InCopy       (InCopy),
      .FirStart     (FirStart),
      .RisingTone   (RisingTone),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt),
      .overrun      (overrun),
      .err_copy     (err_copy)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Scoreboard: every frame_done must match the oldest expected completion
   always @(negedge sys_clk) begin
      if (frame_done) begin
         if (exp_q.size() == 0) begin
            check_eq("done_unexpected", frame_done, 1'b0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("done_cycle", cyc, e.cyc);
            check_eq("done_cnt", frame_cnt, e.cnt);
         end
      end
   end

   // Caller has just entered COPY; n cycles of copy, InCopyEnd on the last one
   task automatic copy_phase(input int n, input int n_rdy);
      for (int i = 0; i < n; i++) begin
         check_eq("incopy_hi", InCopy, 1'b1);
         ready_in  = (i >= 1 && i <= n_rdy);
         InCopyEnd = (i == n - 1);
         #1;
         if (ready_in) check_eq("ready_gated", ready, 1'b0);
         tick();
         ready_in  = 1'b0;
         InCopyEnd = 1'b0;
      end
      check_eq("incopy_lo", InCopy, 1'b0);
      check_eq("fir_pre", FirStart, 1'b0);
      check_eq("ready_replay", ready, (n_rdy > 0));
      tick();
      check_eq("fir_pulse", FirStart, 1'b1);
      check_eq("ready_after", ready, 1'b0);
   endtask

   task automatic process_phase(input int ps1, input int ps2, input int tog);
      for (int i = 0; i < OUT_LEN; i++) begin
         OutBufwea    = 1'b1;
         ProcessStart = (i == ps1) || (i == ps2);
         if (i == tog) mode_req = ~mode_req;
         if (i == tog + 1) check_eq("tone_hold", RisingTone, exp_tone);
         if (i == OUT_LEN - 1) begin
            exp_frames++;
            exp_q.push_back('{cyc: cyc + 1, cnt: exp_frames % (1 << CNT_BITS)});
         end
         tick();
         OutBufwea    = 1'b0;
         ProcessStart = 1'b0;
      end
   endtask

   task automatic start_frame(input logic m);
      mode_req     = m;
      ProcessStart = 1'b1;
      tick();
      ProcessStart = 1'b0;
      exp_tone     = m;
      check_eq("tone_latch", RisingTone, exp_tone);
      check_eq("busy_copy", busy, 1'b1);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b0; enable = 1'b0; mode_req = 1'b0; ready_in = 1'b0;
      ProcessStart = 1'b0; InCopyEnd = 1'b0; OutBufwea = 1'b0; clr_err = 1'b0;
      repeat (3) tick();
      check_eq("rst_incopy", InCopy, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_fir", FirStart, 1'b0);
      check_eq("rst_cnt", frame_cnt, 0);
      check_eq("rst_ovr", overrun, 1'b0);
      check_eq("rst_errc", err_copy, 1'b0);
      check_eq("rst_ready", ready, 1'b0);
      reset = 1'b1;
      tick();
      enable = 1'b1;
      tick();
      check_eq("wait_busy", busy, 1'b0);
      ready_in = 1'b1;
      #1;
      check_eq("ready_pass", ready, 1'b1);
      tick();
      ready_in = 1'b0;

      // Frame 1: single sample during copy is replayed, no overrun
      start_frame(1'b1);
      copy_phase(6, 1);
      check_eq("ovr_single", overrun, 1'b0);
      process_phase(-1, -1, -1);
      check_eq("f1_wait", busy, 1'b0);
      check_eq("f1_done", frame_done, 1'b1);
      tick();
      check_eq("f1_done_pulse", frame_done, 1'b0);

      // Frame 2: two samples during copy overrun; tone ignores mid-frame change
      start_frame(1'b0);
      copy_phase(8, 2);
      check_eq("ovr_double", overrun, 1'b1);
      process_phase(-1, -1, 100);
      check_eq("ovr_sticky", overrun, 1'b1);
      check_eq("tone_end", RisingTone, 1'b0);
      pulse_clr();
      check_eq("ovr_clr", overrun, 1'b0);

      // Frame 3: queued start goes straight to COPY, the second start overruns
      start_frame(1'b1);
      copy_phase(5, 0);
      process_phase(50, 200, 300);
      check_eq("ovr_ps", overrun, 1'b1);
      check_eq("f3_to_copy", InCopy, 1'b1);
      exp_tone = 1'b0;
      check_eq("tone_reentry", RisingTone, 1'b0);
      copy_phase(4, 0);
      process_phase(-1, -1, -1);
      check_eq("f4_wait", busy, 1'b0);
      pulse_clr();
      check_eq("ovr_clr2", overrun, 1'b0);

      // Frame 5: start coincident with completion is treated as pending
      start_frame(1'b0);
      copy_phase(4, 0);
      process_phase(OUT_LEN - 1, -1, -1);
      check_eq("f5_to_copy", InCopy, 1'b1);
      check_eq("f5_no_ovr", overrun, 1'b0);

      // Copy timeout with InCopyEnd withheld
      n = 0;
      while (InCopy && n < 100) begin
         n++;
         tick();
      end
      check_eq("tmo_len", n, 32);
      check_eq("tmo_err", err_copy, 1'b1);
      check_eq("tmo_fir_pre", FirStart, 1'b0);
      tick();
      check_eq("tmo_fir", FirStart, 1'b1);

      // Frame 6: enable dropped mid-frame, pending start discarded
      enable = 1'b0;
      process_phase(10, -1, -1);
      check_eq("dis_busy", busy, 1'b0);
      check_eq("dis_cnt", frame_cnt, 6);
      repeat (3) tick();
      check_eq("dis_idle", InCopy | busy, 1'b0);
      pulse_clr();
      check_eq("errc_clr", err_copy, 1'b0);

      // Asynchronous reset in the middle of a frame
      enable = 1'b1;
      tick();
      start_frame(1'b1);
      copy_phase(3, 0);
      check_eq("pre_rst_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      check_eq("arst_fir", FirStart, 1'b0);
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_tone", RisingTone, 1'b0);
      check_eq("arst_cnt", frame_cnt, 0);
      check_eq("arst_incopy", InCopy, 1'b0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check_eq("post_rst_idle", busy, 1'b0);
      check_eq("sb_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
